// File: rtl/alarm_ram_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alarm_ram_pkg
// Description : Shared constants, command mode encodings and FSM state type
//               for the alarm RAM block-operation initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_ram_pkg;

  localparam int RAM_ADDR_W = 13;
  localparam int RAM_DATA_W = 32;
  localparam int RAM_BE_W   = RAM_DATA_W / 8;

  localparam logic [1:0] MODE_FILL = 2'd0;
  localparam logic [1:0] MODE_COPY = 2'd1;
  localparam logic [1:0] MODE_SUM  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alarm_ram_dma.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alarm_ram_dma
// Description : Avalon-MM initiator performing FILL / COPY / SUM block
//               operations on the single-port alarm RAM (1-cycle read
//               latency, no waitrequest). All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_ram_dma
  import alarm_ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int BE_W   = RAM_BE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] m_address,
  output logic [BE_W-1:0]   m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata
);

  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cs_q, cs_d;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                clken_q;
  logic                start_acc;

  // State and registered-output update; reset abandons any operation at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_FILL;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      clken_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      be_q     <= be_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      clken_q  <= 1'b1;
    end
  end

  // Next-state logic; bus outputs are derived from the next state so they
  // appear registered in the same cycle the FSM occupies RD or WR
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    result_d  = result_q;
    wdata_d   = wdata_q;
    start_acc = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          mode_d    = mode;
          src_d     = src_addr;
          dst_d     = dst_addr;
          cnt_d     = length;
          if (mode == MODE_SUM)  acc_d   = '0;
          if (mode == MODE_FILL) wdata_d = pattern;
          if ((length == '0) || (mode == MODE_RSVD)) state_d = S_DONE;
          else if (mode == MODE_FILL)               state_d = S_WR;
          else                                       state_d = S_RD;
        end
      end
      S_RD: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Read data returned for the previous RD cycle is valid here
        src_d = src_q + PTR_ONE;
        if (mode_q == MODE_COPY) begin
          wdata_d = m_readdata;
          state_d = S_WR;
        end else begin
          acc_d   = acc_q + m_readdata;
          cnt_d   = cnt_q - CNT_ONE;
          state_d = (cnt_q == CNT_ONE) ? S_DONE : S_RD;
        end
      end
      S_WR: begin
        dst_d = dst_q + PTR_ONE;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE)        state_d = S_DONE;
        else if (mode_q == MODE_FILL) state_d = S_WR;
        else                          state_d = S_RD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Publish the checksum together with the done pulse
    if ((state_d == S_DONE) && (mode_d == MODE_SUM)) result_d = acc_d;

    cs_d   = (state_d == S_RD) || (state_d == S_WR);
    we_d   = (state_d == S_WR);
    be_d   = cs_d ? {BE_W{1'b1}} : '0;
    addr_d = (state_d == S_RD) ? src_d :
             (state_d == S_WR) ? dst_d : addr_q;
    done_d = (state_d == S_DONE);
    // A zero-length command still shows busy for the one cycle after start
    busy_d = start_acc || (state_d == S_RD) || (state_d == S_WAIT) ||
             (state_d == S_WR);
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign m_address    = addr_q;
  assign m_byteenable = be_q;
  assign m_chipselect = cs_q;
  assign m_write      = we_q;
  assign m_writedata  = wdata_q;
  assign m_clken      = clken_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ram_dma.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alarm_ram_dma
// Description : Self-checking bench for alarm_ram_dma with a RAM slave model
//               and a cycle-tagged scoreboard of expected bus/done events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_ram_dma;

  localparam int K_RD   = 0;
  localparam int K_WR   = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int          kind;
    logic [12:0] addr;
    logic [31:0] data;
    bit          chk;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [12:0] src_addr = '0;
  logic [12:0] dst_addr = '0;
  logic [13:0] length = '0;
  logic [31:0] pattern = '0;
  logic        busy, done;
  logic [31:0] result;
  logic [12:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect, m_write, m_clken;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  logic [31:0] mem [0:8191];
  logic        pre_we = 1'b0;
  logic [12:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  t0 = 0;
  int  nbusy;

  alarm_ram_dma dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .pattern(pattern), .busy(busy), .done(done), .result(result),
    .m_address(m_address), .m_byteenable(m_byteenable),
    .m_chipselect(m_chipselect), .m_write(m_write),
    .m_writedata(m_writedata), .m_clken(m_clken), .m_readdata(m_readdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM slave model: registered read, byte-enabled write, bench preload port
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (m_chipselect && m_clken) begin
      if (m_write) begin
        for (int b = 0; b < 4; b++)
          if (m_byteenable[b]) mem[m_address][8*b +: 8] <= m_writedata[8*b +: 8];
      end else begin
        m_readdata <= mem[m_address];
      end
    end
  end

  // Monitor: pop one expectation per bus cycle or done pulse
  always @(negedge clk) begin
    ev_t e;
    if (m_chipselect) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL bus_unexpected we=%0d addr=0x%0h required=no_access", m_write, m_address);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != (m_write ? K_WR : K_RD) || e.addr != m_address ||
            (m_write && e.data != m_writedata) || e.cyc != cyc - t0 ||
            m_byteenable != 4'hF) begin
          failures++;
          $display("FAIL bus actual kind=%0d addr=0x%0h data=0x%0h be=0x%0h cyc=%0d required kind=%0d addr=0x%0h data=0x%0h be=0xf cyc=%0d",
                   m_write ? K_WR : K_RD, m_address, m_writedata, m_byteenable, cyc - t0,
                   e.kind, e.addr, e.data, e.cyc);
        end
      end
    end
    if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        if (e.kind != K_DONE || e.cyc != cyc - t0 || (e.chk && e.data != result)) begin
          failures++;
          $display("FAIL done actual kind=%0d cyc=%0d result=0x%0h required kind=%0d cyc=%0d result=0x%0h",
                   K_DONE, cyc - t0, result, e.kind, e.cyc, e.data);
        end
      end
    end
  end

  function automatic void push(input int kind, input logic [12:0] a,
                               input logic [31:0] d, input bit chk, input int c);
    ev_t e;
    e.kind = kind; e.addr = a; e.data = d; e.chk = chk; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_ctrl"},
          {42'd0, busy, done, m_chipselect, m_write, m_byteenable, m_clken, m_address},
          {42'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 13'h0});
    check({name, "_data"}, {result, m_writedata}, 64'h0);
  endtask

  task automatic preload(input logic [12:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Start strobe is high for cycle t0; returns at the negedge of cycle t0+1
  task automatic issue(input logic [1:0] md, input logic [12:0] s, input logic [12:0] d,
                       input logic [13:0] len, input logic [31:0] pat);
    @(negedge clk);
    mode = md; src_addr = s; dst_addr = d; length = len; pattern = pat;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int nb);
    bit seen = 1'b0;
    nb = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (busy) nb++;
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_done_timeout actual=no_done required=done", name);
    end
    repeat (3) @(negedge clk);
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    preload(13'h00FF, 32'h1111_1111);
    preload(13'h0104, 32'h2222_2222);
    preload(13'h0010, 32'd1);
    preload(13'h0011, 32'd2);
    preload(13'h0012, 32'd3);
    preload(13'h1FFF, 32'hFFFF_FFFF);
    preload(13'h0000, 32'h0000_0002);

    // FILL: 4 back-to-back writes, done one cycle after the last
    for (int i = 0; i < 4; i++) push(K_WR, 13'h0100 + 13'(i), 32'hDEAD_BEEF, 1'b0, 1 + i);
    push(K_DONE, '0, '0, 1'b0, 5);
    issue(2'd0, 13'h0, 13'h0100, 14'd4, 32'hDEAD_BEEF);
    wait_done("fill", nbusy);
    check("fill_busy_cycles", 64'(nbusy), 64'd4);
    check("fill_below", {32'h0, mem[13'h00FF]}, 64'h1111_1111);
    for (int i = 0; i < 4; i++) check("fill_word", {32'h0, mem[13'h0100 + 13'(i)]}, 64'hDEAD_BEEF);
    check("fill_above", {32'h0, mem[13'h0104]}, 64'h2222_2222);

    // COPY: RD/WAIT/WR per word, done 9 cycles after busy rises
    push(K_RD, 13'h0010, '0, 1'b0, 1); push(K_WR, 13'h0200, 32'd1, 1'b0, 3);
    push(K_RD, 13'h0011, '0, 1'b0, 4); push(K_WR, 13'h0201, 32'd2, 1'b0, 6);
    push(K_RD, 13'h0012, '0, 1'b0, 7); push(K_WR, 13'h0202, 32'd3, 1'b0, 9);
    push(K_DONE, '0, '0, 1'b0, 10);
    issue(2'd1, 13'h0010, 13'h0200, 14'd3, 32'h0);
    wait_done("copy", nbusy);
    check("copy_busy_cycles", 64'(nbusy), 64'd9);
    for (int i = 0; i < 3; i++) check("copy_word", {32'h0, mem[13'h0200 + 13'(i)]}, 64'(i + 1));

    // SUM across the address wrap: 0xFFFFFFFF + 2 = 1 (carry dropped)
    push(K_RD, 13'h1FFF, '0, 1'b0, 1); push(K_RD, 13'h0000, '0, 1'b0, 3);
    push(K_DONE, '0, 32'h0000_0001, 1'b1, 5);
    issue(2'd2, 13'h1FFF, 13'h0, 14'd2, 32'h0);
    wait_done("sum", nbusy);
    check("sum_busy_cycles", 64'(nbusy), 64'd4);
    check("sum_result", {32'h0, result}, 64'h1);

    // Zero-length FILL and reserved mode: no bus access, one-cycle busy
    push(K_DONE, '0, '0, 1'b0, 1);
    issue(2'd0, 13'h0, 13'h0300, 14'd0, 32'hFFFF_FFFF);
    wait_done("len0", nbusy);
    check("len0_busy_cycles", 64'(nbusy), 64'd1);
    push(K_DONE, '0, '0, 1'b0, 1);
    issue(2'd3, 13'h0, 13'h0300, 14'd5, 32'hFFFF_FFFF);
    wait_done("mode3", nbusy);
    check("mode3_busy_cycles", 64'(nbusy), 64'd1);
    check("result_held", {32'h0, result}, 64'h1);

    // start pulsed mid-FILL is ignored: exactly 8 writes, one done
    for (int i = 0; i < 8; i++) push(K_WR, 13'h0500 + 13'(i), 32'h0BAD_F00D, 1'b0, 1 + i);
    push(K_DONE, '0, '0, 1'b0, 9);
    issue(2'd0, 13'h0, 13'h0500, 14'd8, 32'h0BAD_F00D);
    mode = 2'd1; src_addr = 13'h0010; dst_addr = 13'h0700; length = 14'd2; pattern = 32'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("refill", nbusy);
    check("refill_busy_cycles", 64'(nbusy), 64'd7);
    check("refill_last", {32'h0, mem[13'h0507]}, 64'h0BAD_F00D);

    // Reset at the 2nd WR of a 6-word COPY: bus drops at once, no done
    for (int i = 0; i < 6; i++) preload(13'h0020 + 13'(i), 32'h100 + 32'(i));
    preload(13'h0301, 32'h3333_3333);
    push(K_RD, 13'h0020, '0, 1'b0, 1); push(K_WR, 13'h0300, 32'h100, 1'b0, 3);
    push(K_RD, 13'h0021, '0, 1'b0, 4);
    issue(2'd1, 13'h0020, 13'h0300, 14'd6, 32'h0);
    repeat (5) @(posedge clk);
    #2;
    check("abort_in_wr", {49'h0, m_chipselect, m_write, m_address}, {49'h0, 1'b1, 1'b1, 13'h0301});
    reset = 1'b1;
    #1;
    check_reset_vals("abort");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_drained", 64'(exp_q.size()), 64'd0);
    check("abort_first", {32'h0, mem[13'h0300]}, 64'h100);
    check("abort_second", {32'h0, mem[13'h0301]}, 64'h3333_3333);

    // Follow-up command completes normally
    push(K_WR, 13'h0400, 32'h1234_5678, 1'b0, 1); push(K_WR, 13'h0401, 32'h1234_5678, 1'b0, 2);
    push(K_DONE, '0, '0, 1'b0, 3);
    issue(2'd0, 13'h0, 13'h0400, 14'd2, 32'h1234_5678);
    wait_done("post", nbusy);
    check("post_word", {32'h0, mem[13'h0401]}, 64'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
